// File: rtl/mcm_poll_reader_if.sv
// MCM poll reader bus: coordinator handshake, RAM read port,
// telemetry byte stream and status.
interface mcm_poll_reader_if #(
  parameter int ADDR_W = 8
);
  logic              iDone;
  logic              oRQ;
  logic [ADDR_W-1:0] oRdAddr;
  logic [7:0]        iRdData;
  logic [7:0]        oData;
  logic              oValid;
  logic              iReady;
  logic              oBusy;
  logic              oTimeout;
  logic [7:0]        oErrCnt;

  modport master (
    input  iDone, iRdData, iReady,
    output oRQ, oRdAddr, oData, oValid,
    output oBusy, oTimeout, oErrCnt
  );

  modport slave (
    output iDone, iRdData, iReady,
    input  oRQ, oRdAddr, oData, oValid,
    input  oBusy, oTimeout, oErrCnt
  );
endinterface

// File: rtl/mcm_poll_reader.sv
// MCM poll cycle owner: requests a capture, waits for done, then
// streams sync word, RAM payload and checksum to the framer.
module mcm_poll_reader #(
  parameter int          N_BYTES     = 144,
  parameter int          ADDR_W      = 8,
  parameter int          POLL_PERIOD = 50000,
  parameter int          RQ_LEN      = 4,
  parameter int          TIMEOUT     = 20000,
  parameter logic [15:0] SYNC_WORD   = 16'hA55A
) (
  input logic               clk,
  input logic               reset,
  mcm_poll_reader_if.master bus
);
  localparam int PW   = $clog2(POLL_PERIOD);
  localparam int TMAX = (TIMEOUT > RQ_LEN) ? TIMEOUT : RQ_LEN;
  localparam int TW   = $clog2(TMAX);

  localparam logic [PW-1:0]     POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0]     RQ_LAST   = TW'(RQ_LEN - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, SYNC_H, SYNC_L, PAYLOAD, CSUM
  } state_t;

  state_t            state, stateN;
  logic [PW-1:0]     pollCnt;
  logic [TW-1:0]     tmr, tmrN;
  logic [ADDR_W-1:0] idx, idxN;
  logic [7:0]        csum, csumN;
  logic [7:0]        errCnt, errN;
  logic              vld, vldN;
  logic              toPulse, toN;
  logic              tick;
  logic [7:0]        dataSel;

  assign tick = (pollCnt == POLL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pollCnt <= '0;
    else if (tick) pollCnt <= '0;
    else           pollCnt <= pollCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmr     <= '0;
      idx     <= '0;
      csum    <= '0;
      errCnt  <= '0;
      vld     <= 1'b0;
      toPulse <= 1'b0;
    end else begin
      state   <= stateN;
      tmr     <= tmrN;
      idx     <= idxN;
      csum    <= csumN;
      errCnt  <= errN;
      vld     <= vldN;
      toPulse <= toN;
    end
  end

  // Every stream byte gets one low-valid gap clock before it is offered;
  // in PAYLOAD that gap is the RAM read latency.
  always_comb begin
    stateN = state;
    tmrN   = tmr;
    idxN   = idx;
    csumN  = csum;
    errN   = errCnt;
    vldN   = vld;
    toN    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          stateN = REQ;
          tmrN   = '0;
        end
      end
      REQ: begin
        if (tmr == RQ_LAST) begin
          stateN = WAIT;
          tmrN   = '0;
        end else begin
          tmrN = tmr + 1'b1;
        end
      end
      WAIT: begin
        if (bus.iDone) begin
          stateN = SYNC_H;
          csumN  = '0;
          vldN   = 1'b0;
        end else if (tmr == TO_LAST) begin
          stateN = IDLE;
          toN    = 1'b1;
          if (errCnt != 8'hFF) errN = errCnt + 8'd1;
        end else begin
          tmrN = tmr + 1'b1;
        end
      end
      SYNC_H: begin
        if (!vld) begin
          vldN = 1'b1;
        end else if (bus.iReady) begin
          vldN   = 1'b0;
          stateN = SYNC_L;
        end
      end
      SYNC_L: begin
        if (!vld) begin
          vldN = 1'b1;
        end else if (bus.iReady) begin
          vldN   = 1'b0;
          idxN   = '0;
          stateN = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!vld) begin
          vldN = 1'b1;
        end else if (bus.iReady) begin
          vldN  = 1'b0;
          csumN = csum + bus.iRdData;
          if (idx == IDX_LAST) stateN = CSUM;
          else                 idxN   = idx + 1'b1;
        end
      end
      CSUM: begin
        if (!vld) begin
          vldN = 1'b1;
        end else if (bus.iReady) begin
          vldN   = 1'b0;
          idxN   = '0;
          stateN = IDLE;
        end
      end
      default: begin
        stateN = IDLE;
        vldN   = 1'b0;
      end
    endcase
  end

  always_comb begin
    dataSel = '0;
    unique case (state)
      SYNC_H:  dataSel = SYNC_WORD[15:8];
      SYNC_L:  dataSel = SYNC_WORD[7:0];
      PAYLOAD: dataSel = bus.iRdData;
      CSUM:    dataSel = csum;
      default: dataSel = '0;
    endcase
  end

  assign bus.oRQ      = (state == REQ);
  assign bus.oBusy    = (state != IDLE);
  assign bus.oRdAddr  = (state == PAYLOAD) ? idx : '0;
  assign bus.oData    = vld ? dataSel : '0;
  assign bus.oValid   = vld;
  assign bus.oTimeout = toPulse;
  assign bus.oErrCnt  = errCnt;
endmodule
